poly_load_unit: RTL and testbench

//  Upstream feeder for the unified NTT/INTT core. Accepts a 256-coefficient polynomial as a valid/ready

---
 rtl/poly_load_unit_pkg.sv | 34 +++
 rtl/poly_load_unit_mod_q_reduce.sv | 18 +
 rtl/poly_load_unit.sv | 154 +++++++++++++++
 tb/tb_poly_load_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_load_unit_pkg.sv
// Shared constants, lane packing helper and FSM encoding for the polynomial load unit.
package poly_load_unit_pkg;

    localparam int WIDTH  = 23;
    localparam int Q      = 8380417;
    localparam int NCOEF  = 256;
    localparam int TAG_W  = 9;
    localparam int LANE_W = 1 + WIDTH + TAG_W;   // 33
    localparam int LANES  = 4;
    localparam int WORD_W = LANES * LANE_W;      // 132
    localparam int NWORDS = NCOEF / LANES;       // 64
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 8;
    localparam int MODE_W = 3;

    localparam logic [WIDTH-1:0]  Q_MOD            = WIDTH'(Q);
    localparam logic [MODE_W-1:0] FORWARD_NTT_MODE = 3'd0;
    localparam logic [MODE_W-1:0] INVERSE_NTT_MODE = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_KICK = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    typedef logic [LANE_W-1:0] lane_t;

    // Lane layout: {pad, reduced coefficient, twiddle tag}.
    function automatic lane_t pack_lane(input logic [WIDTH-1:0] c, input logic [TAG_W-1:0] t);
        return {1'b0, c, t};
    endfunction

endpackage

// File: rtl/poly_load_unit_mod_q_reduce.sv
// Single conditional subtract reduction; valid because 2*Q exceeds the input range.
module mod_q_reduce #(
    parameter int               WIDTH = 23,
    parameter logic [WIDTH-1:0] Q     = 23'd8380417
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] y_o
);

    // Subtract Q once when the input is at or above the modulus.
    always_comb begin
        y_o = x_i;
        if (x_i >= Q) begin
            y_o = x_i - Q;
        end
    end

endmodule

// File: rtl/poly_load_unit.sv
// Streams 256 coefficients in, reduces mod Q, packs 4 lanes per BRAM word,
// then kicks the NTT core and waits for its completion pulse.
module poly_load_unit
    import poly_load_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [MODE_W-1:0] mode_in,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTH-1:0]  s_coeff,
    input  logic [TAG_W-1:0]  s_tag,
    input  logic              s_last,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [WORD_W-1:0] bram_din,
    output logic              ntt_start,
    output logic [MODE_W-1:0] ntt_mode,
    input  logic              ntt_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    lane_t [LANES-2:0]       hold_q, hold_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [WORD_W-1:0]       din_q, din_d;
    logic [MODE_W-1:0]       mode_q, mode_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [WIDTH-1:0]        coeff_red;
    lane_t                   lane_new;
    logic                    beat;
    logic                    is_final;
    logic                    frame_bad;
    logic                    last_wr;

    mod_q_reduce #(
        .WIDTH (WIDTH),
        .Q     (Q_MOD)
    ) u_red (
        .x_i (s_coeff),
        .y_o (coeff_red)
    );

    assign lane_new  = pack_lane(coeff_red, s_tag);
    assign is_final  = (cnt_q == CNT_W'(NCOEF - 1));
    // s_last must appear on the final beat and nowhere else.
    assign frame_bad = (s_last != is_final);
    // The final word write is on the bus; no more beats are taken while it drains.
    assign last_wr   = we_q && (addr_q == ADDR_W'(NWORDS - 1));
    assign s_ready   = (state_q == ST_LOAD) && !last_wr;
    assign beat      = s_valid && s_ready;

    assign bram_we   = we_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign ntt_start = (state_q == ST_KICK);
    assign ntt_mode  = mode_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

    // Next-state: sequencing, beat counting, lane accumulation and word staging.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_LOAD;
                    mode_d  = mode_in;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (last_wr) begin
                    state_d = ST_KICK;
                end else if (beat) begin
                    if (frame_bad) begin
                        // Partial word in the holding register is simply abandoned.
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        case (cnt_q[1:0])
                            2'd0: hold_d[0] = lane_new;
                            2'd1: hold_d[1] = lane_new;
                            2'd2: hold_d[2] = lane_new;
                            default: begin
                                // Fourth lane bypasses the holder straight into the word.
                                we_d   = 1'b1;
                                addr_d = cnt_q[7:2];
                                din_d  = {lane_new, hold_q};
                            end
                        endcase
                    end
                end
            end
            ST_KICK: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ntt_done) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_poly_load_unit.sv
// Bench for poly_load_unit: table vectors for reduction, model-based image checks
// for ramp / random / gapped streams, plus framing, handshake and reset sequences.
module tb_poly_load_unit;

    localparam int QM = 8380417;

    logic         clk = 1'b0;
    logic         rst, go, s_valid, s_ready, s_last, bram_we, ntt_start, ntt_done, busy, done, err;
    logic [2:0]   mode_in, ntt_mode;
    logic [22:0]  s_coeff;
    logic [8:0]   s_tag;
    logic [5:0]   bram_addr;
    logic [131:0] bram_din;

    always #5 clk = ~clk;

    poly_load_unit dut (
        .clk(clk), .rst(rst), .go(go), .mode_in(mode_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_coeff(s_coeff), .s_tag(s_tag), .s_last(s_last),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .ntt_start(ntt_start), .ntt_mode(ntt_mode), .ntt_done(ntt_done),
        .busy(busy), .done(done), .err(err)
    );

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int acc_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;

    // Passive capture of everything the DUT writes or signals.
    logic [131:0] cap_mem [64];
    int           wr_log[$];
    int           wr_acc_log[$];
    int           start_total = 0;
    int           start_neg = 0;
    int           mode_errs = 0;
    logic [2:0]   exp_mode = 3'd0;

    always @(negedge clk) begin
        if (bram_we) begin
            cap_mem[bram_addr] = bram_din;
            wr_log.push_back(int'(bram_addr));
            wr_acc_log.push_back(acc_cnt);
        end
        if (ntt_start) begin
            start_total++;
            start_neg = cyc;
        end
        if (busy && ntt_mode !== exp_mode) mode_errs++;
    end

    // Stimulus data and reference model.
    logic [22:0] coef [256];
    logic [8:0]  tag  [256];
    int          last_neg;

    typedef struct {
        logic [22:0] coeff;
        logic [22:0] red;
    } red_vec_t;
    red_vec_t rv [8];

    function automatic logic [131:0] model_word(input int w);
        logic [131:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            int          c;
            logic [32:0] lane;
            c    = int'(coef[4*w+j]) % QM;
            lane = {1'b0, 23'(c), tag[4*w+j]};
            r    = r | (132'(lane) << (33*j));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [131:0] act, input logic [131:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            coef[i] = 23'($urandom);
            tag[i]  = 9'($urandom);
        end
    endtask

    task automatic pulse_go(input logic [2:0] m);
        @(negedge clk);
        exp_mode = m;
        go       = 1'b1;
        mode_in  = m;
        @(negedge clk);
        go       = 1'b0;
        mode_in  = ~m;
    endtask

    task automatic send(input int nbeats, input int last_at, input int gap_pct);
        int to;
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_coeff = coef[i];
            s_tag   = tag[i];
            s_last  = (i == last_at);
            to = 0;
            while (!s_ready && to < 200) begin
                @(negedge clk);
                to++;
            end
            if (!s_ready) begin
                chk("ready_timeout", i, -1);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            last_neg = cyc;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_start(input int base);
        int to;
        to = 0;
        while (start_total == base && to < 20) begin
            @(negedge clk);
            to++;
        end
        chk("start_seen", start_total - base, 1);
    endtask

    task automatic finish_core(input string nm);
        @(negedge clk);
        ntt_done = 1'b1;
        @(negedge clk);
        ntt_done = 1'b0;
        chk1({nm, "_done_pulse"}, done, 1'b1);
        chk1({nm, "_busy_with_done"}, busy, 1'b0);
        @(negedge clk);
        chk1({nm, "_done_single"}, done, 1'b0);
    endtask

    task automatic check_image(input string nm, input int base, input int nw);
        int bad_addr;
        int bad_word;
        bad_addr = 0;
        bad_word = 0;
        chk({nm, "_wr_count"}, wr_log.size() - base, nw);
        for (int w = 0; w < nw; w++) begin
            if (base + w < wr_log.size() && wr_log[base + w] != w) bad_addr++;
            if (cap_mem[w] !== model_word(w)) begin
                bad_word++;
                if (bad_word == 1) chkw({nm, "_first_bad_word"}, cap_mem[w], model_word(w));
            end
        end
        chk({nm, "_addr_order_errs"}, bad_addr, 0);
        chk({nm, "_word_errs"}, bad_word, 0);
    endtask

    initial begin
        int base, sbase, abase;
        logic [131:0] wv;

        rst = 1'b0; go = 1'b0; mode_in = '0; s_valid = 1'b0; s_coeff = '0;
        s_tag = '0; s_last = 1'b0; ntt_done = 1'b0;

        // ---- reset state ----
        #2 rst = 1'b1;
        #1;
        chk1("rst_s_ready", s_ready, 1'b0);
        chk1("rst_bram_we", bram_we, 1'b0);
        chk1("rst_ntt_start", ntt_start, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_ntt_mode", int'(ntt_mode), 0);
        chkw("rst_bram_din", bram_din, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---- 1: ramp ----
        for (int i = 0; i < 256; i++) begin
            coef[i] = 23'(i);
            tag[i]  = 9'(i);
        end
        base = wr_log.size(); sbase = start_total;
        pulse_go(3'd0);
        chk1("ramp_busy", busy, 1'b1);
        send(256, 255, 0);
        wait_start(sbase);
        check_image("ramp", base, 64);
        chkw("ramp_word63", cap_mem[63][131:99], 132'({1'b0, 23'd255, 9'd255}));
        chk("ramp_start_latency", start_neg - last_neg, 2);
        chk("ramp_mode", int'(ntt_mode), 0);
        finish_core("ramp");

        // ---- 2: reduction table ----
        rv[0] = '{23'd8380416, 23'd8380416};
        rv[1] = '{23'd8380417, 23'd0};
        rv[2] = '{23'd8380422, 23'd5};
        rv[3] = '{23'd8388607, 23'd8190};
        rv[4] = '{23'd0,       23'd0};
        rv[5] = '{23'd1,       23'd1};
        rv[6] = '{23'd8380418, 23'd1};
        rv[7] = '{23'd8380415, 23'd8380415};
        fill_random();
        for (int k = 0; k < 8; k++) coef[k] = rv[k].coeff;
        base = wr_log.size(); sbase = start_total;
        pulse_go(3'd0);
        send(256, 255, 0);
        wait_start(sbase);
        for (int k = 0; k < 8; k++) begin
            wv = cap_mem[k/4];
            chk($sformatf("red_row%0d", k), int'(wv[33*(k%4)+9 +: 23]), int'(rv[k].red));
            chk1($sformatf("red_pad%0d", k), wv[33*(k%4)+32], 1'b0);
        end
        check_image("red", base, 64);
        finish_core("red");

        // ---- 3: backpressure / gaps, inverse mode ----
        fill_random();
        base = wr_log.size(); sbase = start_total; abase = acc_cnt;
        pulse_go(3'd1);
        send(256, 255, 30);
        wait_start(sbase);
        check_image("gap", base, 64);
        if (wr_acc_log.size() > base) chk("gap_first_wr_beats", wr_acc_log[base] - abase, 4);
        else chk("gap_first_wr_missing", 0, 1);
        chk("gap_mode_run", int'(ntt_mode), 1);
        finish_core("gap");
        chk("gap_mode_after", int'(ntt_mode), 1);

        // ---- 4: framing errors ----
        fill_random();
        base = wr_log.size(); sbase = start_total;
        pulse_go(3'd0);
        send(101, 100, 0);
        repeat (4) @(negedge clk);
        chk1("frame_err", err, 1'b1);
        chk1("frame_busy", busy, 1'b0);
        chk("frame_no_start", start_total - sbase, 0);
        check_image("frame", base, 25);
        pulse_go(3'd0);
        chk1("frame_err_cleared", err, 1'b0);
        base = wr_log.size();
        send(256, 999, 0);
        repeat (4) @(negedge clk);
        chk1("nolast_err", err, 1'b1);
        chk1("nolast_busy", busy, 1'b0);
        chk("nolast_no_start", start_total - sbase, 0);
        check_image("nolast", base, 63);

        // ---- 5: handshake corner cases ----
        fill_random();
        base = wr_log.size(); sbase = start_total;
        pulse_go(3'd0);
        chk1("hs_err_cleared", err, 1'b0);
        @(negedge clk); ntt_done = 1'b1;
        @(negedge clk); ntt_done = 1'b0;
        chk1("hs_done_in_load", done, 1'b0);
        chk1("hs_busy_in_load", busy, 1'b1);
        send(256, 255, 0);
        wait_start(sbase);
        @(negedge clk); go = 1'b1; mode_in = 3'd5;
        @(negedge clk); go = 1'b0; mode_in = 3'd0;
        chk("hs_mode_after_go_in_run", int'(ntt_mode), 0);
        chk1("hs_busy_after_go_in_run", busy, 1'b1);
        repeat (2) @(negedge clk);
        chk("hs_single_start", start_total - sbase, 1);
        check_image("hs", base, 64);
        finish_core("hs");
        @(negedge clk); ntt_done = 1'b1;
        @(negedge clk); ntt_done = 1'b0;
        chk1("hs_done_in_idle", done, 1'b0);
        chk1("hs_busy_in_idle", busy, 1'b0);

        // ---- 6: async reset mid-load ----
        fill_random();
        pulse_go(3'd1);
        send(132, 999, 0);
        chk1("rstmid_write_pending", bram_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("rstmid_bram_we", bram_we, 1'b0);
        chk("rstmid_bram_addr", int'(bram_addr), 0);
        chkw("rstmid_bram_din", bram_din, '0);
        chk1("rstmid_busy", busy, 1'b0);
        chk1("rstmid_s_ready", s_ready, 1'b0);
        chk("rstmid_mode", int'(ntt_mode), 0);
        @(negedge clk);
        rst = 1'b0;
        fill_random();
        base = wr_log.size(); sbase = start_total;
        pulse_go(3'd2);
        send(256, 255, 0);
        wait_start(sbase);
        check_image("reload", base, 64);
        finish_core("reload");

        chk("mode_stable_while_busy", mode_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
